// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Owns the architectural program counter. Fetches one instruction at a time
// from instruction memory over a req/ack handshake, holds it for decode on a
// valid/ready handshake, and on acceptance steps the PC either sequentially
// (pc+4) or to a PC-relative branch target (pc+4+sext(imm16)<<2).
//
// Parameters
//   RESET_PC     PC loaded on reset (word aligned)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse, starts fetching from pc when idle
//   halt         level, at acceptance returns to idle instead of refetching
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch address (always equals pc_out)
//   imem_ack     memory returns imem_rdata this cycle
//   imem_rdata   fetched instruction word
//   instr_out    registered instruction presented to decode
//   instr_valid  instr_out holds an unaccepted instruction
//   instr_ready  decode accepts instr_out this cycle
//   branch_taken branch decision for instr_out, sampled at acceptance
//   pc_out       current PC
//   retired      number of accepted instructions, wraps
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding, nothing presented; waits for start
// FETCH | imem_req high at pc, waiting for imem_ack
// ISSUE | instr_out valid, waiting for instr_ready; next pc chosen here
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_out,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             branch_taken,
    output logic [31:0]      pc_out,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;

    // Next-PC datapath; all sums are modulo 2^32, carry-out dropped.
    logic [31:0] pc_seq;
    logic [31:0] branch_off;
    logic [31:0] pc_next;
    logic        accept;

    assign pc_seq     = pc + 32'd4;
    assign branch_off = {{14{instr_out[15]}}, instr_out[15:0], 2'b00};
    assign pc_next    = branch_taken ? (pc_seq + branch_off) : pc_seq;

    // instr_valid is only ever high in ISSUE, so ready outside ISSUE is
    // ignored by construction.
    assign accept = (state == ISSUE) && instr_valid && instr_ready;

    // The fetch address is the PC register itself, so it cannot drift from
    // pc_out and is registered.
    assign imem_addr = pc;
    assign pc_out    = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_out   <= 32'd0;
            instr_valid <= 1'b0;
            retired     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    // halt is evaluated only at acceptance, so start wins here.
                    if (start) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end

                FETCH: begin
                    if (imem_ack) begin
                        instr_out   <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Stray imem_ack here is ignored: instr_out only loads in FETCH.
                    if (accept) begin
                        pc          <= pc_next;
                        instr_valid <= 1'b0;
                        retired     <= retired + CNT_W'(1);
                        if (halt) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start, halt, imem_ack, instr_ready, branch_taken;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr_out, pc_out;
    logic [15:0] retired;

    // Second instance: top-of-memory reset PC and a narrow counter so that
    // both PC wrap and retired wrap are reachable in a few instructions.
    logic        w_start, w_halt, w_imem_ack, w_instr_ready, w_branch_taken;
    logic [31:0] w_imem_rdata;
    logic        w_imem_req, w_instr_valid;
    logic [31:0] w_imem_addr, w_instr_out, w_pc_out;
    logic [1:0]  w_retired;

    int checks;
    int failures;

    logic [31:0] q_addr[$];
    logic [31:0] q_instr[$];
    logic [31:0] exp_v;

    pc_fetch_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .branch_taken(branch_taken),
        .pc_out(pc_out), .retired(retired)
    );

    pc_fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(w_start), .halt(w_halt),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack),
        .imem_rdata(w_imem_rdata), .instr_out(w_instr_out), .instr_valid(w_instr_valid),
        .instr_ready(w_instr_ready), .branch_taken(w_branch_taken),
        .pc_out(w_pc_out), .retired(w_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        start = 0; halt = 0; imem_ack = 0; imem_rdata = 0; instr_ready = 0; branch_taken = 0;
        w_start = 0; w_halt = 0; w_imem_ack = 0; w_imem_rdata = 0; w_instr_ready = 0; w_branch_taken = 0;
        q_addr.delete();
        q_instr.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pop_addr(output logic [31:0] v);
        if (q_addr.size() > 0) v = q_addr.pop_front();
        else v = 32'hXXXX_XXXX;
    endtask

    task automatic pop_instr(output logic [31:0] v);
        if (q_instr.size() > 0) v = q_instr.pop_front();
        else v = 32'hXXXX_XXXX;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 32'd0 ||
            pc_out !== 32'd0 || imem_addr !== 32'd0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h addr=%h ret=%0d, required 0,0,0,0,0,0",
                     imem_req, instr_valid, instr_out, pc_out, imem_addr, retired);
        end
        checks++;
        if (w_pc_out !== 32'hFFFF_FFFC || w_imem_addr !== 32'hFFFF_FFFC || w_retired !== 2'd0) begin
            failures++;
            $display("FAIL reset_state_wrap: pc=%h addr=%h ret=%0d, required fffffffc fffffffc 0",
                     w_pc_out, w_imem_addr, w_retired);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL seq_start_latency: imem_req=%b, required 1", imem_req);
        end
        q_addr.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            pop_addr(exp_v);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_v) begin
                failures++;
                $display("FAIL seq_fetch_addr[%0d]: req=%b addr=%h, required 1 %h", i, imem_req, imem_addr, exp_v);
            end
            imem_ack = 1'b1;
            imem_rdata = 32'h2000_0001;
            q_instr.push_back(32'h2000_0001);
            halt = (i == 2);
            @(negedge clk);
            imem_ack = 1'b0;
            pop_instr(exp_v);
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_out !== exp_v) begin
                failures++;
                $display("FAIL seq_issue[%0d]: valid=%b req=%b instr=%h, required 1 0 %h",
                         i, instr_valid, imem_req, instr_out, exp_v);
            end
            q_addr.push_back(32'((i + 1) * 4));
            @(negedge clk);
            checks++;
            if (retired !== 16'(i + 1) || instr_valid !== 1'b0 || imem_req !== (i < 2)) begin
                failures++;
                $display("FAIL seq_accept[%0d]: retired=%0d valid=%b req=%b, required %0d 0 %b",
                         i, retired, instr_valid, imem_req, i + 1, (i < 2));
            end
        end
        halt = 1'b0;
        pop_addr(exp_v);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (imem_req !== 1'b0 || pc_out !== exp_v) begin
                failures++;
                $display("FAIL halt_idle[%0d]: req=%b pc=%h, required 0 %h", k, imem_req, pc_out, exp_v);
            end
            @(negedge clk);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hA5A5_0010;
        q_instr.push_back(32'hA5A5_0010);
        @(negedge clk);
        imem_ack = 1'b0;
        pop_instr(exp_v);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== exp_v || pc_out !== 32'h0 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b instr=%h pc=%h req=%b, required 1 %h 0 0",
                         k, instr_valid, instr_out, pc_out, imem_req, exp_v);
            end
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || retired !== 16'd1) begin
            failures++;
            $display("FAIL bp_release: req=%b addr=%h ret=%0d, required 1 00000004 1", imem_req, imem_addr, retired);
        end
    endtask

    task automatic test_branch();
        logic [31:0] words[5];
        logic        takes[5];
        logic [31:0] nexts[5];
        words = '{32'h1000_0003, 32'h1000_FFFC, 32'h1000_0002, 32'h1000_0003, 32'h1234_FFF0};
        takes = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        nexts = '{32'h10, 32'h04, 32'h10, 32'h20, 32'h24};
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        q_addr.push_back(32'h0);
        for (int i = 0; i < 5; i++) begin
            pop_addr(exp_v);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_v) begin
                failures++;
                $display("FAIL branch_addr[%0d]: req=%b addr=%h, required 1 %h", i, imem_req, imem_addr, exp_v);
            end
            imem_ack = 1'b1;
            imem_rdata = words[i];
            branch_taken = takes[i];
            halt = (i == 4);
            q_addr.push_back(nexts[i]);
            @(negedge clk);
            imem_ack = 1'b0;
            @(negedge clk);
        end
        pop_addr(exp_v);
        checks++;
        if (pc_out !== exp_v || imem_req !== 1'b0 || retired !== 16'd5) begin
            failures++;
            $display("FAIL branch_final: pc=%h req=%b ret=%0d, required %h 0 5", pc_out, imem_req, retired, exp_v);
        end
        halt = 1'b0;
        branch_taken = 1'b0;
        instr_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold[%0d]: req=%b addr=%h valid=%b, required 1 0 0", k, imem_req, imem_addr, instr_valid);
            end
            if (k == 3) begin
                imem_ack = 1'b1;
                imem_rdata = 32'h0BAD_1234;
                q_instr.push_back(32'h0BAD_1234);
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        pop_instr(exp_v);
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== exp_v) begin
            failures++;
            $display("FAIL wait_issue: valid=%b instr=%h, required 1 %h", instr_valid, instr_out, exp_v);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== exp_v || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL spurious_ack: valid=%b instr=%h req=%b, required 1 %h 0", instr_valid, instr_out, imem_req, exp_v);
        end
        instr_ready = 1'b1;
        halt = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        halt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_out !== 32'h4 || retired !== 16'd1) begin
                failures++;
                $display("FAIL wait_halt[%0d]: req=%b valid=%b pc=%h ret=%0d, required 0 0 00000004 1",
                         k, imem_req, instr_valid, pc_out, retired);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addrs[5];
        logic [1:0]  exp_ret[5];
        exp_addrs = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
        exp_ret   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        w_instr_ready = 1'b1;
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (w_imem_req !== 1'b1 || w_imem_addr !== exp_addrs[i]) begin
                failures++;
                $display("FAIL wrap_addr[%0d]: req=%b addr=%h, required 1 %h", i, w_imem_req, w_imem_addr, exp_addrs[i]);
            end
            w_imem_ack = 1'b1;
            w_imem_rdata = 32'h0000_0040;
            w_halt = (i == 4);
            @(negedge clk);
            w_imem_ack = 1'b0;
            @(negedge clk);
            checks++;
            if (w_retired !== exp_ret[i]) begin
                failures++;
                $display("FAIL wrap_retired[%0d]: retired=%0d, required %0d", i, w_retired, exp_ret[i]);
            end
        end
        w_halt = 1'b0;
        w_instr_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h1111_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        instr_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            failures++;
            $display("FAIL rstmid_pre: req=%b addr=%h, required 1 00000004", imem_req, imem_addr);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc_out !== 32'h0 || imem_addr !== 32'h0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_async: req=%b pc=%h addr=%h ret=%0d, required 0 0 0 0", imem_req, pc_out, imem_addr, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || instr_out !== 32'h0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL late_ack: valid=%b instr=%h req=%b, required 0 0 0", instr_valid, instr_out, imem_req);
        end
    endtask

    task automatic test_start_halt();
        do_reset();
        start = 1'b1;
        halt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL start_over_halt: req=%b, required 1", imem_req);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'h7777_0001;
        instr_ready = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== 32'h7777_0001) begin
            failures++;
            $display("FAIL halt_fetch_completes: valid=%b instr=%h, required 1 77770001", instr_valid, instr_out);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || retired !== 16'd1 || pc_out !== 32'h4) begin
            failures++;
            $display("FAIL halt_stop: req=%b valid=%b ret=%0d pc=%h, required 0 0 1 00000004",
                     imem_req, instr_valid, retired, pc_out);
        end
        halt = 1'b0;
        instr_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 0; halt = 0; imem_ack = 0; imem_rdata = 0; instr_ready = 0; branch_taken = 0;
        w_start = 0; w_halt = 0; w_imem_ack = 0; w_imem_rdata = 0; w_instr_ready = 0; w_branch_taken = 0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch();
        test_wait_states();
        test_wrap();
        test_reset_mid();
        test_start_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
